// File: rtl/ex_stage_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ex_stage_pipe_pkg
// Shared types for the LC-3b execute stage: the ALU operation encoding
// (including the multi-cycle multiply) and the multiplier FSM state type.
// Optional feature macro: EX_MUL_EN (iterative multiplier present).
// -----------------------------------------------------------------------------
package ex_stage_pipe_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_AND  = 3'd1,
      ALU_NOT  = 3'd2,
      ALU_PASS = 3'd3,
      ALU_SLL  = 3'd4,
      ALU_SRL  = 3'd5,
      ALU_SRA  = 3'd6,
      ALU_MUL  = 3'd7
   } lc3b_alu_op;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } ex_mul_state_t;

   // True for operations that run on the iterative multiplier
   function automatic logic f_is_multicycle(input lc3b_alu_op op);
      return (op == ALU_MUL);
   endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// -----------------------------------------------------------------------------
// ex_stage_pipe_if
// Bundles the execute-stage handshake and data signals.
//   master : upstream/downstream environment (drives operation, out_ready, flush)
//   slave  : the execute stage (drives in_ready, out_valid/result/tag, busy)
// Signals: flush, in_valid/in_ready, in_op, in_src1/in_src2/in_imm, in_imm_sel,
//          in_tag, fwd_data, fwd_sel_a/fwd_sel_b, out_valid/out_ready,
//          out_result, out_tag, busy.
// Optional feature macro: EX_MUL_EN (affects busy behaviour only).
// -----------------------------------------------------------------------------
interface ex_stage_pipe_if #(
   parameter int WIDTH = 16,
   parameter int NFWD  = 3,
   parameter int TAGW  = 8
);
   import ex_stage_pipe_pkg::*;

   localparam int SELW = $clog2(NFWD + 1);

   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   lc3b_alu_op             in_op;
   logic [WIDTH-1:0]       in_src1;
   logic [WIDTH-1:0]       in_src2;
   logic [WIDTH-1:0]       in_imm;
   logic                   in_imm_sel;
   logic [TAGW-1:0]        in_tag;
   logic [NFWD*WIDTH-1:0]  fwd_data;
   logic [SELW-1:0]        fwd_sel_a;
   logic [SELW-1:0]        fwd_sel_b;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_result;
   logic [TAGW-1:0]        out_tag;
   logic                   busy;

   modport master (
      output flush, in_valid, in_op, in_src1, in_src2, in_imm, in_imm_sel,
             in_tag, fwd_data, fwd_sel_a, fwd_sel_b, out_ready,
      input  in_ready, out_valid, out_result, out_tag, busy
   );

   modport slave (
      input  flush, in_valid, in_op, in_src1, in_src2, in_imm, in_imm_sel,
             in_tag, fwd_data, fwd_sel_a, fwd_sel_b, out_ready,
      output in_ready, out_valid, out_result, out_tag, busy
   );

endinterface

// File: rtl/ex_stage_pipe_mul_iter.sv
// -----------------------------------------------------------------------------
// ex_mul_iter
// Iterative shift-add multiplier, one multiplier bit per cycle, product kept
// modulo 2^WIDTH. Used by ex_stage_pipe only when EX_MUL_EN is defined.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_flush      abort a running multiply (wins over start/completion)
//   i_start      start a multiply with i_a x i_b
//   o_busy       FSM in MUL state
//   o_done       final iteration this cycle; o_product is valid
//   o_product    product (combinational, valid while o_done)
// -----------------------------------------------------------------------------
module ex_mul_iter
   import ex_stage_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int CW = $clog2(WIDTH);

   ex_mul_state_t    r_state;
   ex_mul_state_t    w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_acc_nxt;

   // r_a is pre-shifted each cycle, so r_b[0] selects the term A<<i
   assign w_acc_nxt = r_acc + (r_b[0] ? r_a : {WIDTH{1'b0}});
   assign o_product = w_acc_nxt;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_flush) begin
               w_state_nxt = IDLE;
            end else if (i_start) begin
               w_state_nxt = MUL;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         MUL: begin
            if (i_flush) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == {CW{1'b0}}) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = MUL;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         MUL: begin
            o_busy = 1'b1;
            o_done = (r_cnt == {CW{1'b0}}) && !i_flush;
         end
         default: begin
            o_busy = 1'b0;
            o_done = 1'b0;
         end
      endcase
   end

   // Shift-add datapath and iteration counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= {CW{1'b0}};
         r_acc <= {WIDTH{1'b0}};
         r_a   <= {WIDTH{1'b0}};
         r_b   <= {WIDTH{1'b0}};
      end else if (i_flush) begin
         r_cnt <= {CW{1'b0}};
      end else if ((r_state == IDLE) && i_start) begin
         r_cnt <= CW'(WIDTH - 1);
         r_acc <= {WIDTH{1'b0}};
         r_a   <= i_a;
         r_b   <= i_b;
      end else if (r_state == MUL) begin
         r_acc <= w_acc_nxt;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1);
         end else begin
            r_cnt <= r_cnt;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/ex_stage_pipe.sv
// -----------------------------------------------------------------------------
// ex_stage_pipe
// LC-3b execute stage: operand forwarding, ALU (add/and/not/pass/shifts),
// optional iterative multiplier, and an EX/MEM output register with
// valid/ready handshakes on both sides.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   ex_stage_pipe_if.slave (operation in, result out, flush, busy)
// Optional feature macro: EX_MUL_EN
//   defined   : alu_mul runs on ex_mul_iter for WIDTH cycles, busy reflects it
//   undefined : no multiplier; alu_mul completes in one cycle with result 0
// -----------------------------------------------------------------------------
module ex_stage_pipe
   import ex_stage_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NFWD  = 3,
   parameter int TAGW  = 8
) (
   input logic           clk,
   input logic           rst,
   ex_stage_pipe_if.slave bus
);

   localparam int SELW = $clog2(NFWD + 1);
   localparam int SHW  = $clog2(WIDTH);

   logic             w_in_ready;
   logic             w_accept;
   logic             w_single;
   logic             w_busy;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_product;
   logic [TAGW-1:0]  w_mul_tag;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH-1:0] w_local_b;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_alu;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic [TAGW-1:0]  r_out_tag;

   // Selects 0 = local operand, k = forwarding source k-1; anything beyond
   // NFWD matches no source and resolves to zero.
   function automatic logic [WIDTH-1:0] f_pick(
      input logic [SELW-1:0]        sel,
      input logic [WIDTH-1:0]       loc,
      input logic [NFWD*WIDTH-1:0]  fwd
   );
      logic [WIDTH-1:0] v;
      v = {WIDTH{1'b0}};
      if (sel == {SELW{1'b0}}) begin
         v = loc;
      end else begin
         for (int k = 0; k < NFWD; k++) begin
            v = (sel == SELW'(k + 1)) ? fwd[k*WIDTH +: WIDTH] : v;
         end
      end
      return v;
   endfunction

   // Stalled output, running multiply and flush all block acceptance
   assign w_in_ready = !w_busy && !bus.flush && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   assign w_local_b = bus.in_imm_sel ? bus.in_imm : bus.in_src2;
   assign w_op_a    = f_pick(bus.fwd_sel_a, bus.in_src1, bus.fwd_data);
   assign w_op_b    = f_pick(bus.fwd_sel_b, w_local_b, bus.fwd_data);
   assign w_shamt   = w_op_b[SHW-1:0];

   // Single-cycle ALU
   always_comb begin
      w_alu = {WIDTH{1'b0}};
      case (bus.in_op)
         ALU_ADD:  w_alu = w_op_a + w_op_b;
         ALU_AND:  w_alu = w_op_a & w_op_b;
         ALU_NOT:  w_alu = ~w_op_a;
         ALU_PASS: w_alu = w_op_b;
         ALU_SLL:  w_alu = w_op_a << w_shamt;
         ALU_SRL:  w_alu = w_op_a >> w_shamt;
         ALU_SRA:  w_alu = $signed(w_op_a) >>> w_shamt;
         ALU_MUL:  w_alu = {WIDTH{1'b0}};
         default:  w_alu = {WIDTH{1'b0}};
      endcase
   end

`ifdef EX_MUL_EN
   logic             w_mul_start;
   logic [TAGW-1:0]  r_mul_tag;

   assign w_single    = !f_is_multicycle(bus.in_op);
   assign w_mul_start = w_accept && !w_single;
   assign w_mul_tag   = r_mul_tag;

   ex_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (bus.flush),
      .i_start   (w_mul_start),
      .i_a       (w_op_a),
      .i_b       (w_op_b),
      .o_busy    (w_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // Tag of the multiply in flight, captured at acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul_tag <= {TAGW{1'b0}};
      end else if (w_mul_start) begin
         r_mul_tag <= bus.in_tag;
      end else begin
         r_mul_tag <= r_mul_tag;
      end
   end
`else
   assign w_single      = 1'b1;
   assign w_busy        = 1'b0;
   assign w_mul_done    = 1'b0;
   assign w_mul_product = {WIDTH{1'b0}};
   assign w_mul_tag     = {TAGW{1'b0}};
`endif

   // EX/MEM output register; flush beats completion, acceptance and drain.
   // A multiply can only complete with the register empty, since it was
   // accepted with the register free and nothing else enters while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_result <= {WIDTH{1'b0}};
         r_out_tag    <= {TAGW{1'b0}};
      end else if (bus.flush) begin
         r_out_valid  <= 1'b0;
      end else if (w_mul_done) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_mul_product;
         r_out_tag    <= w_mul_tag;
      end else if (w_accept && w_single) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_alu;
         r_out_tag    <= bus.in_tag;
      end else if (bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end else begin
         r_out_valid  <= r_out_valid;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_tag    = r_out_tag;
   assign bus.busy       = w_busy;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_ex_stage_pipe
// Directed bench for ex_stage_pipe (WIDTH=16, NFWD=3, TAGW=8). A negedge
// monitor pushes the expected result of every accepted operation and pops it
// when the output handshake completes; the main sequence adds direct checks
// of timing, back-pressure, flush and reset. Honours EX_MUL_EN.
// -----------------------------------------------------------------------------
module tb_ex_stage_pipe;
   import ex_stage_pipe_pkg::*;

   localparam int W = 16;
   localparam int T = 8;

   logic clk;
   logic rst;

   int errs   = 0;
   int checks = 0;

   logic [T+W-1:0] sb[$];
   logic [T+W-1:0] mon_exp;

   ex_stage_pipe_if #(.WIDTH(W), .NFWD(3), .TAGW(T)) bus_if ();

   ex_stage_pipe #(.WIDTH(W), .NFWD(3), .TAGW(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] loc,
                                         input logic [3*W-1:0] fwd);
      if (sel == 2'd0) return loc;
      return fwd[(int'(sel) - 1)*W +: W];
   endfunction

   function automatic logic [W-1:0] model(input lc3b_alu_op op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_AND:  r = a & b;
         ALU_NOT:  r = ~a;
         ALU_PASS: r = b;
         ALU_SLL:  r = a << b[3:0];
         ALU_SRL:  r = a >> b[3:0];
         ALU_SRA:  r = $signed(a) >>> b[3:0];
`ifdef EX_MUL_EN
         ALU_MUL:  r = a * b;
`else
         ALU_MUL:  r = 16'h0000;
`endif
         default:  r = 16'h0000;
      endcase
      return r;
   endfunction

   // Scoreboard: pop on output handshake, push on input acceptance
   always @(negedge clk) begin
      if (rst || bus_if.flush) begin
         sb.delete();
      end else begin
         if (bus_if.out_valid && bus_if.out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               mon_exp = sb.pop_front();
               chk("sb_result", 32'(bus_if.out_result), 32'(mon_exp[W-1:0]));
               chk("sb_tag", 32'(bus_if.out_tag), 32'(mon_exp[T+W-1:W]));
            end
         end
         if (bus_if.in_valid && bus_if.in_ready) begin
            sb.push_back({bus_if.in_tag,
               model(bus_if.in_op,
                     pick(bus_if.fwd_sel_a, bus_if.in_src1, bus_if.fwd_data),
                     pick(bus_if.fwd_sel_b,
                          bus_if.in_imm_sel ? bus_if.in_imm : bus_if.in_src2,
                          bus_if.fwd_data))});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input lc3b_alu_op op, input logic [W-1:0] s1, input logic [W-1:0] s2,
                        input logic [W-1:0] imm, input logic isel, input logic [T-1:0] tag,
                        input logic [1:0] sa, input logic [1:0] sbs);
      bus_if.in_op      = op;
      bus_if.in_src1    = s1;
      bus_if.in_src2    = s2;
      bus_if.in_imm     = imm;
      bus_if.in_imm_sel = isel;
      bus_if.in_tag     = tag;
      bus_if.fwd_sel_a  = sa;
      bus_if.fwd_sel_b  = sbs;
      bus_if.in_valid   = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      bus_if.flush      = 1'b0;
      bus_if.in_valid   = 1'b0;
      bus_if.in_op      = ALU_ADD;
      bus_if.in_src1    = 16'h0000;
      bus_if.in_src2    = 16'h0000;
      bus_if.in_imm     = 16'h0000;
      bus_if.in_imm_sel = 1'b0;
      bus_if.in_tag     = 8'h00;
      bus_if.fwd_sel_a  = 2'd0;
      bus_if.fwd_sel_b  = 2'd0;
      bus_if.out_ready  = 1'b1;
      // source0=00F0, source1=1234, source2=0008
      bus_if.fwd_data   = {16'h0008, 16'h1234, 16'h00F0};

      repeat (2) tick();
      chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_out_result", 32'(bus_if.out_result), 32'd0);
      chk("rst_out_tag", 32'(bus_if.out_tag), 32'd0);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

      // add with overflow into bit 15, result next cycle
      drive(ALU_ADD, 16'h7FFF, 16'h0000, 16'h0001, 1'b1, 8'h05, 2'd0, 2'd0);
      tick();
      chk("add_valid", 32'(bus_if.out_valid), 32'd1);
      chk("add_result", 32'(bus_if.out_result), 32'h8000);
      chk("add_tag", 32'(bus_if.out_tag), 32'h05);

      // forwarded A (source 1), local src1 ignored
      drive(ALU_SRA, 16'hFFFF, 16'h0000, 16'h0004, 1'b1, 8'h06, 2'd2, 2'd0);
      tick();
      chk("fwd_sra_result", 32'(bus_if.out_result), 32'h0123);
      chk("fwd_sra_tag", 32'(bus_if.out_tag), 32'h06);

      // back-to-back single-cycle ops, checked by the scoreboard
      drive(ALU_SLL,  16'h0001, 16'h0000, 16'h0000, 1'b0, 8'h07, 2'd0, 2'd3);
      tick();
      drive(ALU_AND,  16'hF0F0, 16'h0000, 16'h0000, 1'b0, 8'h08, 2'd0, 2'd1);
      tick();
      drive(ALU_NOT,  16'h1234, 16'h0000, 16'h0000, 1'b0, 8'h09, 2'd0, 2'd0);
      tick();
      chk("not_result", 32'(bus_if.out_result), 32'hEDCB);
      drive(ALU_PASS, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 8'h0A, 2'd0, 2'd0);
      tick();
      drive(ALU_SRL,  16'h8000, 16'h0000, 16'h000F, 1'b1, 8'h0B, 2'd0, 2'd0);
      tick();
      drive(ALU_SRA,  16'h8000, 16'h0000, 16'h000F, 1'b1, 8'h0C, 2'd0, 2'd0);
      tick();
      chk("sra_sign_result", 32'(bus_if.out_result), 32'hFFFF);
      drive(ALU_ADD,  16'hFFFF, 16'h0002, 16'h0000, 1'b0, 8'h0D, 2'd0, 2'd0);
      tick();

      // back-pressure: result held while stalled, accept on drain cycle
      drive(ALU_PASS, 16'h0000, 16'h0000, 16'hAAAA, 1'b1, 8'h10, 2'd0, 2'd0);
      tick();
      bus_if.out_ready = 1'b0;
      drive(ALU_ADD, 16'h0001, 16'h0001, 16'h0000, 1'b0, 8'h11, 2'd0, 2'd0);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
         chk("stall_result", 32'(bus_if.out_result), 32'hAAAA);
         chk("stall_valid", 32'(bus_if.out_valid), 32'd1);
         tick();
      end
      bus_if.out_ready = 1'b1;
      #1;
      chk("drain_in_ready", 32'(bus_if.in_ready), 32'd1);
      tick();
      chk("drain_result", 32'(bus_if.out_result), 32'h0002);
      chk("drain_tag", 32'(bus_if.out_tag), 32'h11);
      bus_if.in_valid = 1'b0;
      tick();
      chk("drained_valid", 32'(bus_if.out_valid), 32'd0);

      // multiply 3 x FFFF
      drive(ALU_MUL, 16'h0003, 16'hFFFF, 16'h0000, 1'b0, 8'h20, 2'd0, 2'd0);
      tick();
      bus_if.in_valid = 1'b0;
`ifdef EX_MUL_EN
      for (int i = 0; i < W; i++) begin
         chk("mul_busy", 32'(bus_if.busy), 32'd1);
         chk("mul_in_ready", 32'(bus_if.in_ready), 32'd0);
         chk("mul_valid_early", 32'(bus_if.out_valid), 32'd0);
         tick();
      end
      chk("mul_valid", 32'(bus_if.out_valid), 32'd1);
      chk("mul_result", 32'(bus_if.out_result), 32'hFFFD);
      chk("mul_tag", 32'(bus_if.out_tag), 32'h20);
      chk("mul_busy_done", 32'(bus_if.busy), 32'd0);
      tick();
`else
      chk("mul_valid", 32'(bus_if.out_valid), 32'd1);
      chk("mul_result", 32'(bus_if.out_result), 32'h0000);
      chk("mul_busy", 32'(bus_if.busy), 32'd0);
      drive(ALU_MUL, 16'h0003, 16'h0005, 16'h0000, 1'b0, 8'h21, 2'd0, 2'd0);
      tick();
      chk("mul35_result", 32'(bus_if.out_result), 32'h0000);
      chk("mul35_tag", 32'(bus_if.out_tag), 32'h21);
      bus_if.in_valid = 1'b0;
      tick();
`endif

      // flush kills a stalled result and ignores the same-cycle input
      bus_if.out_ready = 1'b0;
      drive(ALU_PASS, 16'h0000, 16'h0000, 16'h5555, 1'b1, 8'h40, 2'd0, 2'd0);
      tick();
      chk("pre_flush_valid", 32'(bus_if.out_valid), 32'd1);
      bus_if.flush = 1'b1;
      bus_if.out_ready = 1'b1;
      drive(ALU_ADD, 16'h0001, 16'h0001, 16'h0000, 1'b0, 8'h41, 2'd0, 2'd0);
      #1;
      chk("flush_in_ready", 32'(bus_if.in_ready), 32'd0);
      tick();
      bus_if.flush = 1'b0;
      bus_if.in_valid = 1'b0;
      chk("flush_valid", 32'(bus_if.out_valid), 32'd0);
      tick();
      chk("flush_no_accept", 32'(bus_if.out_valid), 32'd0);

`ifdef EX_MUL_EN
      // flush in the middle of a multiply
      drive(ALU_MUL, 16'h0005, 16'h0007, 16'h0000, 1'b0, 8'h30, 2'd0, 2'd0);
      tick();
      bus_if.in_valid = 1'b0;
      repeat (4) tick();
      bus_if.flush = 1'b1;
      drive(ALU_ADD, 16'h0009, 16'h0009, 16'h0000, 1'b0, 8'h3F, 2'd0, 2'd0);
      tick();
      bus_if.flush = 1'b0;
      bus_if.in_valid = 1'b0;
      chk("mflush_busy", 32'(bus_if.busy), 32'd0);
      chk("mflush_valid", 32'(bus_if.out_valid), 32'd0);
      repeat (14) tick();
      chk("mflush_no_result", 32'(bus_if.out_valid), 32'd0);
`endif
      drive(ALU_ADD, 16'h0002, 16'h0003, 16'h0000, 1'b0, 8'h31, 2'd0, 2'd0);
      tick();
      bus_if.in_valid = 1'b0;
      chk("post_flush_valid", 32'(bus_if.out_valid), 32'd1);
      chk("post_flush_result", 32'(bus_if.out_result), 32'h0005);
      tick();

      // asynchronous reset while a result is held
      bus_if.out_ready = 1'b0;
      drive(ALU_PASS, 16'h0000, 16'h0000, 16'h1111, 1'b1, 8'h50, 2'd0, 2'd0);
      tick();
      bus_if.in_valid = 1'b0;
      chk("pre_rst_result", 32'(bus_if.out_result), 32'h1111);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus_if.out_valid), 32'd0);
      chk("arst_result", 32'(bus_if.out_result), 32'd0);
      chk("arst_tag", 32'(bus_if.out_tag), 32'd0);
      tick();
      rst = 1'b0;
      bus_if.out_ready = 1'b1;

`ifdef EX_MUL_EN
      // asynchronous reset in the middle of a multiply
      drive(ALU_MUL, 16'h0003, 16'h0003, 16'h0000, 1'b0, 8'h51, 2'd0, 2'd0);
      tick();
      bus_if.in_valid = 1'b0;
      repeat (2) tick();
      chk("pre_mrst_busy", 32'(bus_if.busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_busy", 32'(bus_if.busy), 32'd0);
      chk("mrst_valid", 32'(bus_if.out_valid), 32'd0);
      tick();
      rst = 1'b0;
      repeat (W + 2) tick();
      chk("mrst_no_result", 32'(bus_if.out_valid), 32'd0);
`endif

      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage for the pipelined LC-3b core: resolves operand forwarding from a configurable number of downstream sources, runs the ALU (including shifts), and holds the result in an EX/MEM output register with valid/ready handshakes on both sides. Adds an iterative multi-cycle multiplier that back-pressures the decode stage while it runs. Sits between the ID/EX pipeline register and the MEM stage; a flush input lets the branch unit kill in-flight work.

## Interface
- WIDTH, 16, datapath width in bits (≥4)
- NFWD, 3, number of forwarding sources (mem, wb, mem_load by default)
- TAGW, 8, width of the opaque tag carried alongside each operation
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  kill accepted/in-flight operation
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept
- in_op  in  lc3b_alu_op  operation
- in_src1, in_src2, in_imm  in  WIDTH each  register operands and pre-extended immediate
- in_imm_sel  in  1  1: operand B = in_imm, 0: in_src2
- in_tag  in  TAGW  passed through unchanged
- fwd_data  in  NFWD*WIDTH  forwarding values; source k at bits [k*WIDTH +: WIDTH]
- fwd_sel_a, fwd_sel_b  in  $clog2(NFWD+1) each  0: local operand, k: fwd source k-1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  WIDTH  result
- out_tag  out  TAGW  tag of result
- busy  out  1  multiplier running

## Operation
- Operand A = fwd_sel_a==0 ? in_src1 : fwd source; operand B = fwd_sel_b==0 ? (in_imm_sel ? in_imm : in_src2) : fwd source. Out-of-range selects (>NFWD) yield 0.
- Forwarding resolved only in the acceptance cycle; multiplier captures operands then.
- Accept when in_valid && in_ready. in_ready = !busy && !flush && (!out_valid || out_ready).
- Single-cycle ops: add, and, not (~A), pass (B), sll/srl/sra by B[$clog2(WIDTH)-1:0]; result written to the output register at acceptance edge.
- alu_mul: FSM IDLE→MUL on acceptance; counter loads WIDTH-1; each MUL cycle adds A<<i when B[i] set; low WIDTH bits kept (modulo 2^WIDTH). On counter==0 the output register is loaded, out_valid set, FSM→IDLE. busy = (state==MUL).
- Output register: out_valid clears on out_ready with no new load; out_result/out_tag held stable while out_valid && !out_ready.
- flush: next edge clears out_valid, FSM→IDLE, counter→0; in_valid in the flush cycle ignored.
- Reset: out_valid=0, out_result=0, out_tag=0, busy=0, state IDLE, in_ready=1 after release.

## Timing
- Single-cycle op accepted at edge t: out_valid=1 after edge t.
- MUL accepted at edge t: busy high after t, out_valid=1 after edge t+WIDTH, busy low same edge; in_ready low during cycles t..t+WIDTH-1 (relative to edge).
- Accept and drain in the same cycle allowed (full throughput 1/cycle for single-cycle ops).
- Output register never overwritten while valid and stalled.
- flush wins over every simultaneous event, including MUL completion and acceptance.

## Configuration
- EX_MUL_EN defined: iterative multiplier and FSM present as above.
- Undefined: no FSM or multiplier logic; busy tied 0; alu_mul completes in one cycle with out_result=0.

## Structure
- lc3b_types gains alu_mul in lc3b_alu_op and a ex_mul_state_t enum (IDLE, MUL).
- One sub-module: ex_mul_iter (shift-add multiplier with start/done, WIDTH parameter), instantiated only under EX_MUL_EN.

## Test plan
- WIDTH=16: add A=0x7FFF, B=imm 0x0001, tag 0x05 → next cycle out_result=0x8000, out_tag=0x05.
- fwd_sel_a=2 (fwd_data src1=0x1234), sra B=4, local src1=0xFFFF → result 0x0123, local ignored.
- mul 0x0003×0xFFFF accepted at t → out_valid at t+16 with 0xFFFD; in_ready low t..t+15, busy high.
- out_ready low 3 cycles with result 0xAAAA held, in_valid high → in_ready low, result stable, accept on drain cycle.
- flush at t+5 of a mul → busy=0 and out_valid=0 next cycle, no result emitted; new add accepted afterwards.
- rst asserted mid-mul → outputs zero immediately (asynchronous); without EX_MUL_EN, mul 3×5 → result 0 after 1 cycle.
